// File: rtl/sprite_desc_reader.sv
// sprite_desc_reader: double-buffered 8-slot sprite descriptor table with a
// per-line scan and a per-pixel hit/address lookup.
//
// Write table is loaded through wea/addr/dina. frame_start copies it into the
// display table, or defers the copy until the running line scan finishes.
// line_start scans the 8 display slots, one per cycle, and builds an active
// mask for the line. While idle, each h_cnt is matched against the active
// slots. The lowest slot that matches produces a registered sprite-sheet
// address.
//
// Optional feature macro: SPRITE_HFLIP_EN. When it is defined, descriptor
// bit 26 mirrors dx horizontally.
module sprite_desc_reader #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wea,
  input  logic [2:0]  addr,
  input  logic [31:0] dina,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic [9:0]  scan_line,
  input  logic [9:0]  h_cnt,
  output logic        scan_busy,
  output logic        sprite_hit,
  output logic [15:0] rom_addr
);

  // Sprite extents widened to 11 bits, so x+W and y+H never wrap.
  localparam logic [10:0] W11 = 11'(SPRITE_W);
  localparam logic [10:0] H11 = 11'(SPRITE_H);
`ifdef SPRITE_HFLIP_EN
  localparam logic [4:0]  DX_MAX = 5'(SPRITE_W - 1);
`endif

  typedef struct packed {
    logic       en;
    logic [3:0] rsvd;
    logic       hflip;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] row;
    logic [2:0] col;
  } desc_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  desc_t      wr_tab   [8];
  desc_t      disp_tab [8];
  logic       pending;

  state_t     state, next_state;
  logic [2:0] slot_q;
  logic [9:0] line_q;
  logic [7:0] act_mask;
  logic [4:0] act_dy [8];

  logic       commit_now;
  logic       slot_active;
  logic [4:0] slot_dy;

  logic       found;
  logic [2:0] sel_row;
  logic [2:0] sel_col;
  logic [4:0] sel_dy;
  logic [4:0] sel_dx;
  logic       hit_d;

  logic       unused_desc_bits;

  assign scan_busy = (state == SCAN);

  // Commit fires on frame_start while idle, or on the first idle cycle after
  // a deferred request.
  assign commit_now = !scan_busy && (frame_start || pending);

  // Write table: one slot is loaded per wea strike.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the tables are cleared on reset because enable=0 must hold for
    // every slot after reset. Leaving this RAM uninitialised would let
    // garbage sprites show on the first frame.
    if (reset) begin
      for (int i = 0; i < 8; i++) wr_tab[i] <= '0;
    end else if (wea) begin
      wr_tab[addr] <= desc_t'(dina);
    end
  end

  // Display table and deferred-commit flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) disp_tab[i] <= '0;
      pending <= 1'b0;
    end else if (commit_now) begin
      // NOTE: non-blocking assignments make the copy take the write table as
      // it was before this edge. A wea on this same cycle stays in the write
      // table only.
      for (int i = 0; i < 8; i++) disp_tab[i] <= wr_tab[i];
      pending <= 1'b0;
    end else if (frame_start) begin
      pending <= 1'b1;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Scan FSM next-state logic.
  always_comb begin
    // NOTE: a default is assigned first so that every path drives next_state
    // and no latch is inferred.
    next_state = state;
    case (state)
      IDLE: if (line_start) next_state = SCAN;
      SCAN: begin
        if (line_start)          next_state = SCAN;
        else if (slot_q == 3'd7) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Vertical test of the slot under examination against the latched line.
  always_comb begin
    slot_active = disp_tab[slot_q].en &&
                  ({1'b0, line_q} >= {1'b0, disp_tab[slot_q].y}) &&
                  ({1'b0, line_q} <  {1'b0, disp_tab[slot_q].y} + H11);
    // The low 5 bits of the difference are exact because dy < SPRITE_H <= 32.
    slot_dy     = line_q[4:0] - disp_tab[slot_q].y[4:0];
  end

  // Scan datapath: slot counter, latched line, active mask and per-slot dy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q   <= '0;
      line_q   <= '0;
      act_mask <= '0;
      for (int i = 0; i < 8; i++) act_dy[i] <= '0;
    end else if (line_start) begin
      slot_q   <= '0;
      line_q   <= scan_line;
      act_mask <= '0;
    end else if (state == SCAN) begin
      act_mask[slot_q] <= slot_active;
      act_dy[slot_q]   <= slot_dy;
      slot_q           <= slot_q + 3'd1;
    end
  end

  // Horizontal match. Slots are walked high to low so the lowest index wins.
  always_comb begin
    logic [4:0] dx5;
    found   = 1'b0;
    sel_row = '0;
    sel_col = '0;
    sel_dy  = '0;
    sel_dx  = '0;
    for (int i = 7; i >= 0; i--) begin
      dx5 = h_cnt[4:0] - disp_tab[i].x[4:0];
`ifdef SPRITE_HFLIP_EN
      if (disp_tab[i].hflip) dx5 = DX_MAX - dx5;
`endif
      if (act_mask[i] &&
          ({1'b0, h_cnt} >= {1'b0, disp_tab[i].x}) &&
          ({1'b0, h_cnt} <  {1'b0, disp_tab[i].x} + W11)) begin
        found   = 1'b1;
        sel_row = disp_tab[i].row;
        sel_col = disp_tab[i].col;
        sel_dy  = act_dy[i];
        sel_dx  = dx5;
      end
    end
  end

  // A hit is only reported while idle and staying idle. This keeps
  // sprite_hit low on every cycle in which scan_busy is high.
  assign hit_d = found && (state == IDLE) && (next_state == IDLE);

  // Registered pixel outputs, one cycle after h_cnt is sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sprite_hit <= 1'b0;
      rom_addr   <= '0;
    end else begin
      sprite_hit <= hit_d;
      rom_addr   <= hit_d ? {sel_row, sel_col, sel_dy, sel_dx} : 16'd0;
    end
  end

  // Descriptor bits the lookup does not use: the reserved field, plus hflip
  // when mirroring is compiled out.
  always_comb begin
    unused_desc_bits = 1'b0;
    for (int i = 0; i < 8; i++) begin
      unused_desc_bits = unused_desc_bits ^ (^disp_tab[i].rsvd);
`ifndef SPRITE_HFLIP_EN
      unused_desc_bits = unused_desc_bits ^ disp_tab[i].hflip;
`endif
    end
  end

endmodule

// File: tb/tb_sprite_desc_reader.sv
// tb_sprite_desc_reader: scoreboard bench for sprite_desc_reader.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge. Each scenario task does its own comparisons.
module tb_sprite_desc_reader;

  logic        clk;
  logic        reset;
  logic        wea;
  logic [2:0]  addr;
  logic [31:0] dina;
  logic        frame_start;
  logic        line_start;
  logic [9:0]  scan_line;
  logic [9:0]  h_cnt;
  logic        scan_busy;
  logic        sprite_hit;
  logic [15:0] rom_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {sprite_hit, rom_addr}, pushed when h_cnt is driven.
  logic [16:0] exp_q [$];

  sprite_desc_reader #(.SPRITE_W(32), .SPRITE_H(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .wea        (wea),
    .addr       (addr),
    .dina       (dina),
    .frame_start(frame_start),
    .line_start (line_start),
    .scan_line  (scan_line),
    .h_cnt      (h_cnt),
    .scan_busy  (scan_busy),
    .sprite_hit (sprite_hit),
    .rom_addr   (rom_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ra(input int row, input int col,
                                     input int dy, input int dx);
    return {3'(row), 3'(col), 5'(dy), 5'(dx)};
  endfunction

  task automatic write_desc(input int slot, input bit en, input bit hflip,
                            input int x, input int y, input int row, input int col);
    wea  = 1'b1;
    addr = 3'(slot);
    dina = {en, 4'b0, hflip, 10'(x), 10'(y), 3'(row), 3'(col)};
    @(negedge clk);
    wea  = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic start_scan(input int line);
    line_start = 1'b1;
    scan_line  = 10'(line);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Counts the remaining busy cycles and checks that sprite_hit stays low.
  task automatic wait_scan(input string name, input int exp_cycles);
    int  n = 0;
    bit  hit_seen = 0;
    while (scan_busy && n < 40) begin
      if (sprite_hit) hit_seen = 1;
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== exp_cycles) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_cycles);
    end
    n_checks++;
    if (hit_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL %s hit_during_busy: got 1 expected 0", name);
    end
  endtask

  task automatic scan(input string name, input int line);
    start_scan(line);
    wait_scan(name, 8);
  endtask

  task automatic pixel(input string name, input int h, input bit hit,
                       input logic [15:0] a);
    logic [16:0] got, exp;
    exp_q.push_back({hit, hit ? a : 16'd0});
    h_cnt = 10'(h);
    @(negedge clk);
    got = {sprite_hit, rom_addr};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s h=%0d: got hit=%0b addr=%h expected hit=%0b addr=%h",
               name, h, got[16], got[15:0], exp[16], exp[15:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({scan_busy, sprite_hit, rom_addr} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b hit=%0b addr=%h expected 0/0/0000",
               scan_busy, sprite_hit, rom_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    scan("reset_scan", 410);
    pixel("reset_empty", 85, 0, 16'd0);
  endtask

  task automatic test_basic();
    write_desc(0, 1, 0, 80, 400, 0, 2);
    pulse_frame();
    scan("basic_scan", 410);
    pixel("basic_hit",    85,  1, ra(0, 2, 10, 5));
    pixel("basic_left",   80,  1, ra(0, 2, 10, 0));
    pixel("basic_right",  111, 1, ra(0, 2, 10, 31));
    pixel("basic_past_x", 112, 0, 16'd0);
    pixel("basic_pre_x",  79,  0, 16'd0);
    scan("basic_scan432", 432);
    pixel("basic_line432", 85, 0, 16'd0);
    scan("basic_scan431", 431);
    pixel("basic_line431", 85, 1, ra(0, 2, 31, 5));
    scan("basic_scan399", 399);
    pixel("basic_line399", 85, 0, 16'd0);
  endtask

  task automatic test_priority();
    write_desc(0, 0, 0, 80, 400, 0, 2);
    write_desc(1, 1, 0, 90, 400, 1, 1);
    write_desc(3, 1, 0, 95, 400, 3, 3);
    pulse_frame();
    scan("prio_scan", 410);
    pixel("prio_overlap", 100, 1, ra(1, 1, 10, 10));
    pixel("prio_only3",   125, 1, ra(3, 3, 10, 30));
    pixel("prio_old0",    85,  0, 16'd0);
  endtask

  task automatic test_shadow();
    write_desc(0, 1, 0, 80, 200, 2, 4);
    scan("shadow_scan1", 210);
    pixel("shadow_uncommitted", 85, 0, 16'd0);
    // A write issued on the same cycle as frame_start stays in the write table.
    wea         = 1'b1;
    addr        = 3'd0;
    dina        = {1'b1, 4'b0, 1'b0, 10'd300, 10'd200, 3'd2, 3'd4};
    frame_start = 1'b1;
    @(negedge clk);
    wea         = 1'b0;
    frame_start = 1'b0;
    scan("shadow_scan2", 210);
    pixel("shadow_committed", 85, 1, ra(2, 4, 10, 5));
    pulse_frame();
    scan("shadow_scan3", 210);
    pixel("shadow_same_cycle_wea", 85,  0, 16'd0);
    pixel("shadow_moved",          305, 1, ra(2, 4, 10, 5));
  endtask

  task automatic test_pending();
    logic [4:0] dx5, dx31;
`ifdef SPRITE_HFLIP_EN
    dx5  = 5'd26;
    dx31 = 5'd0;
`else
    dx5  = 5'd5;
    dx31 = 5'd31;
`endif
    write_desc(5, 1, 1, 500, 300, 5, 6);
    start_scan(310);
    @(negedge clk);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_scan("pending_scan", 5);
    pixel("pending_not_yet", 505, 0, 16'd0);
    scan("pending_rescan", 310);
    pixel("pending_hit",  505, 1, ra(5, 6, 10, dx5));
    pixel("pending_edge", 531, 1, ra(5, 6, 10, dx31));
  endtask

  task automatic test_restart();
    start_scan(410);
    @(negedge clk);
    @(negedge clk);
    start_scan(310);
    wait_scan("restart_scan", 8);
    pixel("restart_stale_mask", 100, 0, 16'd0);
    pixel("restart_new_line",   510, 1, 16'd0 | ra(5, 6, 10, 0) |
`ifdef SPRITE_HFLIP_EN
          16'(21)
`else
          16'(10)
`endif
          );
  endtask

  task automatic test_reset_abort();
    start_scan(310);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (scan_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got %0b expected 0", scan_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    scan("abort_rescan", 310);
    pixel("abort_tables_cleared", 505, 0, 16'd0);
  endtask

  initial begin
    reset       = 1'b1;
    wea         = 1'b0;
    addr        = '0;
    dina        = '0;
    frame_start = 1'b0;
    line_start  = 1'b0;
    scan_line   = '0;
    h_cnt       = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_priority();
    test_shadow();
    test_pending();
    test_restart();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_desc_reader.md
SPRITE_DESC_READER -- requirements
Module: sprite_desc_reader

Interface
REQ-001 SHALL have parameter SPRITE_W, default 32, sprite width in pixels (power of two, max 32).
REQ-002 SHALL have parameter SPRITE_H, default 32, sprite height in pixels (power of two, max 32).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wea  input  1  descriptor write strike.
REQ-006 SHALL have port addr  input  3  descriptor slot index 0..7.
REQ-007 SHALL have port dina  input  32  descriptor: [31] enable, [30:27] reserved, [26] hflip, [25:16] x, [15:6] y, [5:3] rom_row, [2:0] rom_col.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse, commits write table to display table.
REQ-009 SHALL have port line_start  input  1  one-cycle pulse, starts per-line scan.
REQ-010 SHALL have port scan_line  input  10  screen line to scan, sampled with line_start.
REQ-011 SHALL have port h_cnt  input  10  current pixel column.
REQ-012 SHALL have port scan_busy  output  1  high while the line scan runs.
REQ-013 SHALL have port sprite_hit  output  1  registered, an enabled sprite covers h_cnt on the scanned line.
REQ-014 SHALL have port rom_addr  output  16  registered sprite-sheet address {rom_row, rom_col, dy[4:0], dx[4:0]}.

Function
REQ-015 SHALL keep two 8-entry tables: write table (updated by wea) and display table (used for scan).
REQ-016 SHALL write dina into write-table slot addr on the cycle wea is high.
REQ-017 SHALL copy all 8 write-table entries into the display table in one cycle on frame_start while scan_busy is low; a wea on that same cycle lands only in the write table.
REQ-018 SHALL, on frame_start while scan_busy is high, set a pending flag and perform the commit on the first cycle after scan_busy falls.
REQ-019 SHALL implement FSM IDLE -> SCAN -> IDLE; line_start in IDLE latches scan_line and enters SCAN.
REQ-020 SHALL in SCAN examine one display slot per cycle, 0 to 7, asserting scan_busy for exactly 8 cycles, then return to IDLE.
REQ-021 SHALL restart the scan at slot 0 with the new scan_line if line_start arrives during SCAN.
REQ-022 SHALL mark slot i active for the line when enable=1 and y <= scan_line < y+SPRITE_H, computed in 11 bits (no wrap), storing dy = scan_line - y.
REQ-023 SHALL clear the whole active mask on entering SCAN; sprite_hit SHALL be 0 while scan_busy is high.
REQ-024 SHALL, in IDLE, select the lowest-index active slot with x <= h_cnt < x+SPRITE_W (11-bit compare), dx = h_cnt - x.
REQ-025 SHALL register sprite_hit and rom_addr one cycle after h_cnt is sampled (latency 1).
REQ-026 SHALL drive rom_addr to 0 when sprite_hit is 0.
REQ-027 SHALL zero-extend dx, dy into their 5-bit fields when SPRITE_W/SPRITE_H < 32.

Reset
REQ-028 SHALL on reset clear both tables (enable=0), clear the active mask and pending flag, enter IDLE, and drive scan_busy=0, sprite_hit=0, rom_addr=0.
REQ-029 SHALL abort any in-progress scan on reset and discard a pending commit.

Configuration
REQ-030 SHALL, with SPRITE_HFLIP_EN defined, output dx' = SPRITE_W-1-dx for slots whose hflip=1.
REQ-031 SHALL, without SPRITE_HFLIP_EN, ignore descriptor bit 26 and always output unflipped dx.

Verification
REQ-032 Write slot 0 = {enable, x=80, y=400, row 0, col 2}, frame_start, line_start with scan_line=410, h_cnt=85 -> next cycle sprite_hit=1, rom_addr={3'd0,3'd2,5'd10,5'd5}.
REQ-033 Same slot, scan_line=432 or h_cnt=112 -> sprite_hit=0, rom_addr=0.
REQ-034 Slots 1 and 3 overlapping at h_cnt=100 -> rom_addr uses slot 1 fields.
REQ-035 Write slot 0 y=200 without frame_start, scan line 210 -> no hit; after frame_start and rescan -> hit.
REQ-036 frame_start issued 3 cycles into scan -> display table unchanged until scan_busy falls, committed the next cycle; with SPRITE_HFLIP_EN and hflip=1, h_cnt=x+5 -> dx=26.
